icache_refill: RTL and testbench

Refill engine for the instruction cache: the write side of the icache tag store and data RAM. On a lookup miss it issues one line-aligned 8-beat INCR read burst to memory and writes each returned word into the data RAM. It forwards the critical word to the fetch stage, then installs the tag with valid=1. It also performs the valid-clear sweep of all 128 tag entries after reset and on request, because the distributed tag RAM has no reset.

---
 rtl/icache_refill_if.sv | 41 ++++
 rtl/icache_refill.sv | 125 ++++++++++++
 tb/tb_icache_refill.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_refill_if.sv
// Signal bundle for the icache refill engine: fetch miss handshake, memory read
// channel, and the data-RAM / tag-RAM write ports.
interface icache_refill_if;
  logic        miss_req;
  logic [31:0] miss_addr;
  logic        inv_req;
  logic        busy;
  logic        done;
  logic        crit_valid;
  logic [31:0] crit_data;
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic        r_valid;
  logic        r_ready;
  logic [31:0] r_data;
  logic        r_last;
  logic        dwen;
  logic [6:0]  dindex;
  logic [2:0]  doffset;
  logic [31:0] ddata;
  logic        twen;
  logic [6:0]  tindex;
  logic [19:0] ttag;
  logic        tvalid;

  // Engine side.
  modport master (
    input  miss_req, miss_addr, inv_req, ar_ready, r_valid, r_data, r_last,
    output busy, done, crit_valid, crit_data, ar_valid, ar_addr, ar_len, r_ready,
           dwen, dindex, doffset, ddata, twen, tindex, ttag, tvalid
  );

  // Fetch / memory / cache-array side.
  modport slave (
    output miss_req, miss_addr, inv_req, ar_ready, r_valid, r_data, r_last,
    input  busy, done, crit_valid, crit_data, ar_valid, ar_addr, ar_len, r_ready,
           dwen, dindex, doffset, ddata, twen, tindex, ttag, tvalid
  );
endinterface

// File: rtl/icache_refill.sv
// Instruction-cache refill engine: 8-beat line fill with critical-word forward,
// tag install, and a valid-clear sweep of all 128 tag entries.
module icache_refill (
  input logic             clk,
  input logic             rst,
  icache_refill_if.master bus
);

  typedef enum logic [2:0] {StInv, StIdle, StAr, StR, StTag} state_e;

  state_e      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        inv_pend_q, inv_pend_d;
  // Word address of the miss (addr[31:2]); byte offset is never needed.
  logic [29:0] addr_q, addr_d;
  logic [2:0]  beat_q, beat_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StInv;
      cnt_q      <= '0;
      inv_pend_q <= 1'b0;
      addr_q     <= '0;
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inv_pend_q <= inv_pend_d;
      addr_q     <= addr_d;
      beat_q     <= beat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    inv_pend_d = inv_pend_q;
    addr_d     = addr_q;
    beat_d     = beat_q;

    bus.busy       = 1'b1;
    bus.done       = 1'b0;
    bus.crit_valid = 1'b0;
    bus.crit_data  = '0;
    bus.ar_valid   = 1'b0;
    bus.ar_addr    = {addr_q[29:3], 5'b0};
    bus.ar_len     = 8'd7;
    bus.r_ready    = 1'b0;
    bus.dwen       = 1'b0;
    bus.dindex     = '0;
    bus.doffset    = '0;
    bus.ddata      = '0;
    bus.twen       = 1'b0;
    bus.tindex     = '0;
    bus.ttag       = '0;
    bus.tvalid     = 1'b0;

    unique case (state_q)
      StInv: begin
        bus.twen   = 1'b1;
        bus.tindex = cnt_q;
        if (cnt_q == 7'd127) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      StIdle: begin
        bus.busy = 1'b0;
        // Invalidate wins; a held miss_req is picked up again after the sweep.
        if (bus.inv_req || inv_pend_q) begin
          state_d    = StInv;
          cnt_d      = '0;
          inv_pend_d = 1'b0;
        end else if (bus.miss_req) begin
          addr_d  = bus.miss_addr[31:2];
          state_d = StAr;
        end
      end
      StAr: begin
        bus.ar_valid = 1'b1;
        if (bus.ar_ready) begin
          state_d = StR;
          beat_d  = '0;
        end
      end
      StR: begin
        bus.r_ready = 1'b1;
        if (bus.r_valid) begin
          bus.dwen    = 1'b1;
          bus.dindex  = addr_q[9:3];
          bus.doffset = beat_q;
          bus.ddata   = bus.r_data;
          if (beat_q == addr_q[2:0]) begin
            bus.crit_valid = 1'b1;
            bus.crit_data  = bus.r_data;
          end
          beat_d = beat_q + 3'd1;
          // r_last alone ends the burst; the beat count is not cross-checked.
          if (bus.r_last) begin
            state_d = StTag;
          end
        end
      end
      StTag: begin
        bus.twen   = 1'b1;
        bus.tindex = addr_q[9:3];
        bus.ttag   = addr_q[29:10];
        bus.tvalid = 1'b1;
        bus.done   = 1'b1;
        state_d    = StIdle;
      end
      default: begin
        state_d = StInv;
        cnt_d   = '0;
      end
    endcase

    // A request during a refill is deferred until the line is installed.
    if (bus.inv_req && (state_q == StAr || state_q == StR || state_q == StTag)) begin
      inv_pend_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_icache_refill.sv
// Scoreboard bench for icache_refill: stimulus pushes expected cache writes,
// a negedge monitor pops and compares whenever the engine writes.
module tb_icache_refill;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  icache_refill_if bus ();

  icache_refill dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [6:0]  idx;
    logic [19:0] tag;
    logic        vld;
  } tag_t;

  typedef struct packed {
    logic [6:0]  idx;
    logic [2:0]  off;
    logic [31:0] data;
  } dat_t;

  tag_t        tag_q[$];
  dat_t        dat_q[$];
  logic [31:0] crit_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sweep();
    for (int i = 0; i < 128; i++) tag_q.push_back(tag_t'{7'(i), 20'd0, 1'b0});
  endtask

  // Monitor: every cache write / forward must match the head of its queue.
  always @(negedge clk) begin
    tag_t        te;
    dat_t        de;
    logic [31:0] ce;
    if (!rst) begin
      if (bus.ar_valid) check("ar_len", bus.ar_len, 8'd7);
      if (bus.twen) begin
        check("tag_write_expected", tag_q.size() != 0, 1'b1);
        check("no_data_with_tag", bus.dwen, 1'b0);
        if (tag_q.size() != 0) begin
          te = tag_q.pop_front();
          check("tag_write", {bus.tindex, bus.ttag, bus.tvalid}, te);
        end
      end
      if (bus.done) check("done_with_tag", {bus.twen, bus.tvalid}, 2'b11);
      if (bus.dwen) begin
        check("data_write_expected", dat_q.size() != 0, 1'b1);
        if (dat_q.size() != 0) begin
          de = dat_q.pop_front();
          check("data_write", {bus.dindex, bus.doffset, bus.ddata}, de);
        end
      end
      if (bus.crit_valid) begin
        check("crit_with_dwen", bus.dwen, 1'b1);
        check("crit_expected", crit_q.size() != 0, 1'b1);
        if (crit_q.size() != 0) begin
          ce = crit_q.pop_front();
          check("crit_data", bus.crit_data, ce);
        end
      end
    end
  end

  // Release reset and expect the full 128-entry clear, then IDLE.
  task automatic release_sweep();
    int unsigned c0;
    bit          ok;
    push_sweep();
    rst = 1'b0;
    c0  = cyc;
    ok  = 1'b0;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("sweep_ends", ok, 1'b1);
    check("sweep_cycles", cyc - c0, 128);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    check("rst_busy", bus.busy, 1'b1);
    check("rst_quiet", {bus.done, bus.ar_valid, bus.r_ready, bus.dwen, bus.crit_valid}, 5'b0);
    release_sweep();
  endtask

  // mode 0: plain refill; 1: inv_req on beat 3; 2: miss+inv together; 3: rst on beat 4
  task automatic refill(input logic [31:0] addr, input int ar_stall, input int gap_min,
                        input int gap_max, input int mode, input bit fixed,
                        input logic [31:0] dbase);
    logic [31:0] d;
    int unsigned c0;
    int unsigned c1;
    int          stall;
    int          g;
    bit          ok;
    stall         = ar_stall;
    bus.miss_addr = addr;
    bus.miss_req  = 1'b1;
    bus.ar_ready  = (ar_stall == 0);
    if (mode == 2) begin
      bus.inv_req = 1'b1;
      push_sweep();
    end
    c0 = cyc;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      tick();
      bus.inv_req = 1'b0;
      if (bus.ar_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("ar_valid_seen", ok, 1'b1);
    if (!ok) begin
      bus.miss_req = 1'b0;
      return;
    end
    if (mode == 0) check("ar_latency", cyc - c0, 1);
    for (int s = 0; s < ar_stall; s++) begin
      check("ar_hold", {bus.ar_valid, bus.ar_addr}, {1'b1, addr[31:5], 5'b0});
      tick();
    end
    bus.ar_ready = 1'b1;
    check("ar_addr", bus.ar_addr, {addr[31:5], 5'b0});
    tick();
    bus.ar_ready = 1'b0;

    for (int b = 0; b < 8; b++) begin
      g           = int'($urandom_range(gap_max, gap_min));
      bus.r_valid = 1'b0;
      repeat (g) tick();
      stall += g;
      d = fixed ? dbase + 32'(b) : $urandom;
      if (mode == 3 && b == 4) begin
        rst         = 1'b1;
        bus.r_valid = 1'b1;
        bus.r_data  = d;
        tick();
        bus.r_valid  = 1'b0;
        bus.miss_req = 1'b0;
        tick();
        release_sweep();
        return;
      end
      dat_q.push_back(dat_t'{addr[11:5], 3'(b), d});
      if (3'(b) == addr[4:2]) crit_q.push_back(d);
      if (b == 7) tag_q.push_back(tag_t'{addr[11:5], addr[31:12], 1'b1});
      if (b == 7 && mode == 1) push_sweep();
      bus.r_valid = 1'b1;
      bus.r_data  = d;
      bus.r_last  = (b == 7);
      bus.inv_req = (mode == 1 && b == 3);
      tick();
      bus.inv_req = 1'b0;
    end
    bus.r_valid = 1'b0;
    bus.r_last  = 1'b0;

    check("done", bus.done, 1'b1);
    bus.miss_req = 1'b0;
    if (mode == 0) check("done_latency", cyc - c0, 10 + stall);
    tick();
    check("idle_after_done", bus.busy, 1'b0);
    if (mode == 1) begin
      tick();
      check("deferred_sweep_starts", bus.busy, 1'b1);
      c1 = cyc;
      ok = 1'b0;
      for (int k = 0; k < 400; k++) begin
        tick();
        if (!bus.busy) begin
          ok = 1'b1;
          break;
        end
      end
      check("deferred_sweep_ends", ok, 1'b1);
      check("deferred_sweep_cycles", cyc - c1, 128);
    end
  endtask

  initial begin
    bus.miss_req  = 1'b0;
    bus.miss_addr = '0;
    bus.inv_req   = 1'b0;
    bus.ar_ready  = 1'b0;
    bus.r_valid   = 1'b0;
    bus.r_data    = '0;
    bus.r_last    = 1'b0;

    do_reset();
    // Basic refill, back-to-back beats 0xA0..0xA7.
    refill(32'h0001_2344, 0, 0, 0, 0, 1'b1, 32'hA0);
    // Address-channel stall plus gaps before every beat.
    refill(32'h8765_4328, 3, 1, 2, 0, 1'b0, '0);
    // Critical word is the last beat.
    refill(32'hDEAD_BEFC, 0, 0, 0, 0, 1'b0, '0);
    for (int n = 0; n < 8; n++) begin
      refill($urandom, int'($urandom_range(3, 0)), 0, int'($urandom_range(2, 0)), 0, 1'b0, '0);
    end
    refill($urandom, 1, 0, 1, 1, 1'b0, '0);
    refill($urandom, 0, 0, 1, 2, 1'b0, '0);
    refill(32'h0000_0FE0, 0, 0, 1, 3, 1'b0, '0);
    refill($urandom, 2, 0, 2, 0, 1'b0, '0);

    repeat (3) tick();
    check("tag_queue_drained", tag_q.size(), 0);
    check("data_queue_drained", dat_q.size(), 0);
    check("crit_queue_drained", crit_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
